fp_result_pack: RTL and testbench

- Back end of the FP32 add/sub datapath: accepts the result sign from the sign unit plus the raw biased exponent and unnormalized mantissa from the adder.
- Normalizes, rounds to nearest-even and packs an IEEE-754 single-precision word.
- Two-stage pipeline with valid/ready handshake on both sides; full throughput, lossless under backpressure.

---
 rtl/fp_result_pack.sv | 167 ++++++++++++++++
 tb/tb_fp_result_pack.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_pack.sv
// rtl/fp_result_pack.sv - FP32 add/sub back end: normalize, round-to-nearest-even, pack
// Optional status flags {overflow, underflow, inexact} on o_flags when FP_RESULT_PACK_FLAGS_EN is defined.
module fp_result_pack #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_sign,
  input  logic [EXP_W-1:0]        i_exp,
  input  logic [FRAC_W+4:0]       i_man,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [EXP_W+FRAC_W:0]   o_result
`ifdef FP_RESULT_PACK_FLAGS_EN
  ,
  output logic [2:0]              o_flags
`endif
);

  // Normalized mantissa: hidden bit, fraction, then guard/round/sticky.
  localparam int MAN_W = FRAC_W + 4;
  localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic                  s1_move;
  logic                  in_fire;

  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_sign_q,  s1_sign_d;
  logic                  s1_zero_q,  s1_zero_d;
  logic [EXP_W:0]        s1_exp_q,   s1_exp_d;
  logic [MAN_W-1:0]      s1_man_q,   s1_man_d;

  logic                  s2_valid_q, s2_valid_d;
  logic [EXP_W+FRAC_W:0] s2_result_q, s2_result_d;

  logic [EXP_W:0]        lzc;
  logic                  lz_found;
  logic                  norm_zero;
  logic [EXP_W:0]        norm_exp;
  logic [MAN_W-1:0]      norm_man;

  logic                  rnd_inc;
  logic [FRAC_W+1:0]     rnd_sum;
  logic [EXP_W:0]        fin_exp;
  logic [FRAC_W-1:0]     fin_frac;
  logic                  fin_inf;
  logic [EXP_W+FRAC_W:0] pack;

`ifdef FP_RESULT_PACK_FLAGS_EN
  logic                  norm_uf;
  logic                  s1_uf_q, s1_uf_d;
  logic [2:0]            s2_flags_q, s2_flags_d;
  logic [2:0]            pack_flags;
`endif

  // Only i_ready reaches o_ready combinationally; everything else comes from flops.
  assign s1_move = ~s2_valid_q | i_ready;
  assign o_ready = ~s1_valid_q | s1_move;
  assign in_fire = i_valid & o_ready;
  assign o_valid = s2_valid_q;
  assign o_result = s2_result_q;
`ifdef FP_RESULT_PACK_FLAGS_EN
  assign o_flags = s2_flags_q;
`endif

  // Stage 1: count leading zeros below the carry bit, then normalize or flush.
  always_comb begin
    lzc       = '0;
    lz_found  = 1'b0;
    norm_zero = 1'b0;
    norm_exp  = '0;
    norm_man  = '0;
`ifdef FP_RESULT_PACK_FLAGS_EN
    norm_uf   = 1'b0;
`endif
    for (int i = MAN_W - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (i_man[i]) lz_found = 1'b1;
        else          lzc = lzc + EXP_ONE;
      end
    end
    if (i_man == '0) begin
      norm_zero = 1'b1;
    end else if (i_man[MAN_W]) begin
      // Carry: shift right one, folding the dropped bit into sticky.
      norm_exp = {1'b0, i_exp} + EXP_ONE;
      norm_man = {i_man[MAN_W:2], |i_man[1:0]};
    end else if ({1'b0, i_exp} <= lzc) begin
      // No denormals: anything that would need one becomes signed zero.
      norm_zero = 1'b1;
`ifdef FP_RESULT_PACK_FLAGS_EN
      norm_uf   = 1'b1;
`endif
    end else begin
      norm_exp = {1'b0, i_exp} - lzc;
      norm_man = i_man[MAN_W-1:0] << lzc;
    end

    s1_valid_d = in_fire ? 1'b1 : (s1_move ? 1'b0 : s1_valid_q);
    s1_sign_d  = in_fire ? i_sign    : s1_sign_q;
    s1_zero_d  = in_fire ? norm_zero : s1_zero_q;
    s1_exp_d   = in_fire ? norm_exp  : s1_exp_q;
    s1_man_d   = in_fire ? norm_man  : s1_man_q;
`ifdef FP_RESULT_PACK_FLAGS_EN
    s1_uf_d    = in_fire ? norm_uf   : s1_uf_q;
`endif
  end

  // Stage 2: round to nearest even on {L,G,R,S}, detect overflow, pack.
  always_comb begin
    rnd_inc  = s1_man_q[2] & (s1_man_q[3] | s1_man_q[1] | s1_man_q[0]);
    rnd_sum  = {1'b0, s1_man_q[MAN_W-1:3]} + {{(FRAC_W+1){1'b0}}, rnd_inc};
    fin_exp  = s1_exp_q + {{EXP_W{1'b0}}, rnd_sum[FRAC_W+1]};
    fin_frac = rnd_sum[FRAC_W+1] ? '0 : rnd_sum[FRAC_W-1:0];
    fin_inf  = 1'b0;
    if (s1_zero_q) begin
      pack = {s1_sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
    end else if (fin_exp >= EXP_MAX) begin
      fin_inf = 1'b1;
      pack    = {s1_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else begin
      pack = {s1_sign_q, fin_exp[EXP_W-1:0], fin_frac};
    end

    s2_valid_d  = s1_move ? s1_valid_q : s2_valid_q;
    s2_result_d = (s1_move & s1_valid_q) ? pack : s2_result_q;
`ifdef FP_RESULT_PACK_FLAGS_EN
    pack_flags = {fin_inf, s1_uf_q,
                  (~s1_zero_q & (|s1_man_q[2:0])) | s1_uf_q | fin_inf};
    s2_flags_d = (s1_move & s1_valid_q) ? pack_flags : s2_flags_q;
`endif
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_exp_q    <= '0;
      s1_man_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
`ifdef FP_RESULT_PACK_FLAGS_EN
      s1_uf_q     <= 1'b0;
      s2_flags_q  <= '0;
`endif
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_zero_q   <= s1_zero_d;
      s1_exp_q    <= s1_exp_d;
      s1_man_q    <= s1_man_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
`ifdef FP_RESULT_PACK_FLAGS_EN
      s1_uf_q     <= s1_uf_d;
      s2_flags_q  <= s2_flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_fp_result_pack.sv
// tb/tb_fp_result_pack.sv - directed self-checking bench for fp_result_pack
module tb_fp_result_pack;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign;
  logic [7:0]  i_exp;
  logic [27:0] i_man;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
`ifdef FP_RESULT_PACK_FLAGS_EN
  logic [2:0]  o_flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fp_result_pack dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_sign   (i_sign),
    .i_exp    (i_exp),
    .i_man    (i_man),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_result (o_result)
`ifdef FP_RESULT_PACK_FLAGS_EN
    ,
    .o_flags  (o_flags)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Drives one operand with i_ready high and samples after the transfer edge and one edge later.
  task automatic run_vec(input logic s, input logic [7:0] e, input logic [27:0] m,
                         output logic early_v, output logic late_v,
                         output logic [31:0] res, output logic [2:0] flg);
    @(negedge i_clk);
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_sign  = s;
    i_exp   = e;
    i_man   = m;
    @(negedge i_clk);
    i_valid = 1'b0;
    early_v = o_valid;
    @(negedge i_clk);
    late_v = o_valid;
    res    = o_result;
`ifdef FP_RESULT_PACK_FLAGS_EN
    flg = o_flags;
`else
    flg = 3'b000;
`endif
  endtask

  task automatic drain();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++;
    if (o_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", o_result); end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
  endtask

  // Shared by the three directed-vector tables; each table task compares inline.
  task automatic test_normalize();
    logic        vs [3] = '{1'b0, 1'b0, 1'b1};
    logic [27:0] vm [3] = '{28'h4000000, 28'h8000000, 28'h2000000};
    logic [31:0] vr [3] = '{32'h3F800000, 32'h40000000, 32'hBF000000};
    logic ev, lv;
    logic [31:0] res;
    logic [2:0] flg;
    for (int k = 0; k < 3; k++) begin
      run_vec(vs[k], 8'h7F, vm[k], ev, lv, res, flg);
      n_checks++;
      if (ev !== 1'b0) begin n_fail++; $display("FAIL norm_early_valid[%0d]: got %b expected 0", k, ev); end
      n_checks++;
      if (lv !== 1'b1) begin n_fail++; $display("FAIL norm_latency[%0d]: got %b expected 1", k, lv); end
      n_checks++;
      if (res !== vr[k]) begin n_fail++; $display("FAIL norm_result[%0d]: got %h expected %h", k, res, vr[k]); end
`ifdef FP_RESULT_PACK_FLAGS_EN
      n_checks++;
      if (flg !== 3'b000) begin n_fail++; $display("FAIL norm_flags[%0d]: got %b expected 000", k, flg); end
`endif
    end
  endtask

  task automatic test_rounding();
    logic [27:0] vm [3] = '{28'h4000004, 28'h400000C, 28'h7FFFFFC};
    logic [31:0] vr [3] = '{32'h3F800000, 32'h3F800002, 32'h40000000};
    logic ev, lv;
    logic [31:0] res;
    logic [2:0] flg;
    for (int k = 0; k < 3; k++) begin
      run_vec(1'b0, 8'h7F, vm[k], ev, lv, res, flg);
      n_checks++;
      if (lv !== 1'b1 || res !== vr[k]) begin
        n_fail++;
        $display("FAIL rne_result[%0d]: got valid=%b %h expected valid=1 %h", k, lv, res, vr[k]);
      end
`ifdef FP_RESULT_PACK_FLAGS_EN
      n_checks++;
      if (flg !== 3'b001) begin n_fail++; $display("FAIL rne_flags[%0d]: got %b expected 001", k, flg); end
`endif
    end
  endtask

  task automatic test_special();
    logic        vs [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0]  ve [3] = '{8'hFE, 8'h01, 8'h7F};
    logic [27:0] vm [3] = '{28'h8000000, 28'h0400000, 28'h0000000};
    logic [31:0] vr [3] = '{32'h7F800000, 32'h00000000, 32'h80000000};
    logic [2:0]  vf [3] = '{3'b101, 3'b011, 3'b000};
    logic ev, lv;
    logic [31:0] res;
    logic [2:0] flg;
    for (int k = 0; k < 3; k++) begin
      run_vec(vs[k], ve[k], vm[k], ev, lv, res, flg);
      n_checks++;
      if (lv !== 1'b1 || res !== vr[k]) begin
        n_fail++;
        $display("FAIL special_result[%0d]: got valid=%b %h expected valid=1 %h", k, lv, res, vr[k]);
      end
`ifdef FP_RESULT_PACK_FLAGS_EN
      n_checks++;
      if (flg !== vf[k]) begin n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", k, flg, vf[k]); end
`else
      if (flg !== 3'b000 && vf[k] === 3'b111) $display("unreachable");
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic        vs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0]  ve [5] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h00};
    logic [27:0] vm [5] = '{28'h4000000, 28'h8000000, 28'h2000000, 28'h400000C, 28'h0000000};
    logic [31:0] vr [5] = '{32'h3F800000, 32'h40000000, 32'hBF000000, 32'h3F800002, 32'h80000000};
    int acc = 0;
    int outs = 0;
    logic stalled_prev = 1'b0;
    logic drop_seen = 1'b0;
    logic [31:0] held = '0;
    drain();
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      i_ready = !(c >= 3 && c <= 6);
      i_valid = (acc < 5);
      if (acc < 5) begin
        i_sign = vs[acc];
        i_exp  = ve[acc];
        i_man  = vm[acc];
      end
      #1;
      if (stalled_prev) begin
        n_checks++;
        if (o_valid !== 1'b1 || o_result !== held) begin
          n_fail++;
          $display("FAIL stall_hold c%0d: got valid=%b %h expected valid=1 %h", c, o_valid, o_result, held);
        end
      end
      if (!drop_seen && o_ready === 1'b0) begin
        drop_seen = 1'b1;
        n_checks++;
        if (acc != 2 || c != 3) begin
          n_fail++;
          $display("FAIL ready_drop: got accepted=%0d cycle=%0d expected accepted=2 cycle=3", acc, c);
        end
      end
      if (o_valid === 1'b1 && i_ready) begin
        n_checks++;
        if (outs >= 5) begin
          n_fail++;
          $display("FAIL extra_output: got %h expected no output", o_result);
        end else if (o_result !== vr[outs]) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h expected %h", outs, o_result, vr[outs]);
        end
        outs++;
      end
      stalled_prev = (o_valid === 1'b1) && !i_ready;
      held = o_result;
      if (i_valid && o_ready === 1'b1) acc++;
    end
    i_valid = 1'b0;
    n_checks++;
    if (!drop_seen) begin n_fail++; $display("FAIL ready_drop_seen: got 0 expected 1"); end
    n_checks++;
    if (outs != 5) begin n_fail++; $display("FAIL b2b_count: got %0d expected 5", outs); end
    n_checks++;
    if (acc != 5) begin n_fail++; $display("FAIL b2b_accepted: got %0d expected 5", acc); end
  endtask

  task automatic test_async_reset();
    int first_c = -1;
    int vcount = 0;
    logic [31:0] seen = '0;
    drain();
    @(negedge i_clk);
    i_valid = 1'b1; i_sign = 1'b0; i_exp = 8'h7F; i_man = 28'h4000000;
    @(negedge i_clk);
    i_man = 28'h8000000;
    @(negedge i_clk);
    i_valid = 1'b0;
    #2;
    n_checks++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL inflight_valid: got %b expected 1", o_valid); end
    i_rst = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b expected 0", o_valid); end
    n_checks++;
    if (o_result !== 32'h0) begin n_fail++; $display("FAIL async_rst_result: got %h expected 00000000", o_result); end
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", o_ready); end
    @(negedge i_clk);
    i_valid = 1'b1; i_sign = 1'b1; i_exp = 8'h7F; i_man = 28'h2000000;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      #1;
      if (o_valid === 1'b1) begin
        if (first_c < 0) first_c = c;
        vcount++;
        seen = o_result;
      end
    end
    n_checks++;
    if (first_c != 1) begin n_fail++; $display("FAIL post_rst_latency: got cycle %0d expected 1", first_c); end
    n_checks++;
    if (vcount != 1) begin n_fail++; $display("FAIL post_rst_count: got %0d expected 1", vcount); end
    n_checks++;
    if (seen !== 32'hBF000000) begin n_fail++; $display("FAIL post_rst_result: got %h expected bf000000", seen); end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_sign  = 1'b0;
    i_exp   = '0;
    i_man   = '0;
    test_reset();
    test_normalize();
    test_rounding();
    test_special();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
